// File: rtl/noc_switch_allocator_pkg.sv
// Shared types and sizing helpers for the NoC output-port switch allocator.
// The round-robin arbiter is kept generic so the VC allocator can reuse it.
package noc_switch_allocator_pkg;

    localparam int Noc_VC_Channel      = 2;
    localparam int Noc_VC_Credit_Depth = 4;

    typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} noc_alloc_state_e;

    function automatic int credit_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int vc_index_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/noc_switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after i_ptr
// (wrapping modulo NUM_INPUTS) wins.
module noc_rr_arbiter #(
    parameter int NUM_INPUTS = 5,
    parameter int PTR_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS-1:0] i_req,
    input  logic [PTR_W-1:0]      i_ptr,
    output logic [NUM_INPUTS-1:0] o_onehot,
    output logic                  o_any
);

    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] w_idx;

    always_comb begin
        o_onehot = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_idx = {1'b0, i_ptr} + SUM_W'(k);
            if (w_idx >= SUM_W'(NUM_INPUTS)) begin
                w_idx = w_idx - SUM_W'(NUM_INPUTS);
            end
            if (!o_any && i_req[w_idx[PTR_W-1:0]]) begin
                o_onehot[w_idx[PTR_W-1:0]] = 1'b1;
                o_any                      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_switch_allocator.sv
// Per-output-port switch allocator: round-robin head-flit arbitration with
// wormhole locking, plus downstream per-VC credit tracking that gates send_en.
module noc_switch_allocator
    import noc_switch_allocator_pkg::*;
#(
    parameter int NUM_INPUTS   = 5,
    parameter int CHANNELS     = Noc_VC_Channel,
    parameter int CREDIT_DEPTH = Noc_VC_Credit_Depth,
    parameter int VC_W         = vc_index_width(CHANNELS),
    parameter int CNT_W        = credit_cnt_width(CREDIT_DEPTH)
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst,
    input  logic [NUM_INPUTS-1:0]       req,
    input  logic [NUM_INPUTS-1:0]       req_sop,
    input  logic [NUM_INPUTS*VC_W-1:0]  req_vc,
    input  logic                        out_fire,
    input  logic                        out_eop,
    input  logic [CHANNELS-1:0]         credit_return,
    output logic [NUM_INPUTS-1:0]       grant,
    output logic [VC_W-1:0]             grant_vc,
    output logic                        send_en,
    output logic                        busy,
    output logic [CHANNELS*CNT_W-1:0]   credit_cnt,
    output logic                        credit_err
);

    localparam int              PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_DEPTH);

    noc_alloc_state_e        r_state, w_state_next;
    logic [NUM_INPUTS-1:0]   r_grant, w_grant_next;
    logic [VC_W-1:0]         r_grant_vc, w_grant_vc_next;
    logic [PTR_W-1:0]        r_win_idx, w_win_idx_next;
    logic [PTR_W-1:0]        r_rr_ptr, w_rr_ptr_next;
    logic                    r_credit_err;

    logic [CHANNELS-1:0]     w_nonzero;
    logic [CHANNELS-1:0]     w_cred_err;
    logic [(1<<VC_W)-1:0]    w_has_credit;
    logic [NUM_INPUTS-1:0]   w_eligible;
    logic [NUM_INPUTS-1:0]   w_arb_onehot;
    logic                    w_arb_any;
    logic [PTR_W-1:0]        w_arb_idx;
    logic [VC_W-1:0]         w_arb_vc;
    logic                    w_busy;

    assign w_busy = (r_state == ALLOC_LOCKED);

    genvar gi;

    // Unused VC encodings (non power-of-two CHANNELS) never look creditworthy.
    for (gi = 0; gi < (1 << VC_W); gi++) begin : g_vc_pad
        if (gi < CHANNELS) begin : g_real
            assign w_has_credit[gi] = w_nonzero[gi];
        end else begin : g_pad
            assign w_has_credit[gi] = 1'b0;
        end
    end

    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_elig
        assign w_eligible[gi] = req[gi] & req_sop[gi] & w_has_credit[req_vc[gi*VC_W +: VC_W]];
    end

    noc_rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS),
        .PTR_W      (PTR_W)
    ) u_arb (
        .i_req    (w_eligible),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_arb_onehot),
        .o_any    (w_arb_any)
    );

    always_comb begin
        w_arb_idx = '0;
        w_arb_vc  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_arb_onehot[i]) begin
                w_arb_idx = PTR_W'(i);
                w_arb_vc  = req_vc[i*VC_W +: VC_W];
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_grant_vc_next = r_grant_vc;
        w_win_idx_next  = r_win_idx;
        w_rr_ptr_next   = r_rr_ptr;
        case (r_state)
            ALLOC_IDLE: begin
                if (w_arb_any) begin
                    w_state_next    = ALLOC_LOCKED;
                    w_grant_next    = w_arb_onehot;
                    w_grant_vc_next = w_arb_vc;
                    w_win_idx_next  = w_arb_idx;
                end
            end
            ALLOC_LOCKED: begin
                // Only a transferred tail releases the lock; req dropping does not.
                if (out_fire && out_eop) begin
                    w_state_next  = ALLOC_IDLE;
                    w_grant_next  = '0;
                    w_rr_ptr_next = (r_win_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : r_win_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = ALLOC_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            r_state    <= ALLOC_IDLE;
            r_grant    <= '0;
            r_grant_vc <= '0;
            r_win_idx  <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_grant_vc <= w_grant_vc_next;
            r_win_idx  <= w_win_idx_next;
            r_rr_ptr   <= w_rr_ptr_next;
        end
    end

    for (gi = 0; gi < CHANNELS; gi++) begin : g_credit
        logic             w_dec;
        logic             w_inc;
        logic [CNT_W-1:0] r_cnt;

        assign w_dec = out_fire & w_busy & (r_grant_vc == VC_W'(gi));
        assign w_inc = credit_return[gi];
        // Overflow and underflow are dropped rather than wrapped.
        assign w_cred_err[gi] = (w_inc & ~w_dec & (r_cnt == FULL)) |
                                (w_dec & ~w_inc & (r_cnt == '0));

        always_ff @(posedge noc_clk or posedge noc_rst) begin
            if (noc_rst) begin
                r_cnt <= FULL;
            end else if (w_inc && !w_dec && r_cnt != FULL) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_dec && !w_inc && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign w_nonzero[gi]                  = (r_cnt != '0);
        assign credit_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            r_credit_err <= 1'b0;
        end else if ((|w_cred_err) || (out_fire && !w_busy)) begin
            r_credit_err <= 1'b1;
        end
    end

    assign grant      = r_grant;
    assign grant_vc   = r_grant_vc;
    assign busy       = w_busy;
    assign send_en    = w_busy & w_has_credit[r_grant_vc];
    assign credit_err = r_credit_err;

    a_grant_onehot0: assert property (@(posedge noc_clk) disable iff (noc_rst) $onehot0(grant));
    a_fire_needs_send: assert property (@(posedge noc_clk) disable iff (noc_rst) out_fire |-> send_en);

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed bench for noc_switch_allocator: an abstract per-cycle model is
// compared every cycle, and hand-computed literals pin the key scenarios.
module tb_noc_switch_allocator;

    logic       noc_clk = 1'b0;
    logic       noc_rst;
    logic [4:0] req, req_sop, req_vc;
    logic       out_fire, out_eop;
    logic [1:0] credit_return;
    logic [4:0] grant;
    logic       grant_vc;
    logic       send_en, busy;
    logic [5:0] credit_cnt;
    logic       credit_err;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    noc_switch_allocator dut (
        .noc_clk       (noc_clk),
        .noc_rst       (noc_rst),
        .req           (req),
        .req_sop       (req_sop),
        .req_vc        (req_vc),
        .out_fire      (out_fire),
        .out_eop       (out_eop),
        .credit_return (credit_return),
        .grant         (grant),
        .grant_vc      (grant_vc),
        .send_en       (send_en),
        .busy          (busy),
        .credit_cnt    (credit_cnt),
        .credit_err    (credit_err)
    );

    always #5 noc_clk = ~noc_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: credits as plain integers, lock as owner index.
    int m_cred [2];
    int m_old  [2];
    bit m_locked;
    int m_owner;
    int m_vc;
    int m_ptr;
    bit m_err;
    bit m_was_locked;
    bit m_found;
    bit m_dec, m_inc;
    int m_i;

    always @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            m_cred[0] = 4; m_cred[1] = 4;
            m_locked = 0; m_owner = 0; m_vc = 0; m_ptr = 0; m_err = 0;
        end else begin
            m_old[0] = m_cred[0]; m_old[1] = m_cred[1];
            m_was_locked = m_locked;
            if (out_fire && !m_was_locked) m_err = 1;
            for (int c = 0; c < 2; c++) begin
                m_dec = out_fire && m_was_locked && (m_vc == c);
                m_inc = credit_return[c];
                if (m_dec && !m_inc) begin
                    if (m_cred[c] == 0) m_err = 1; else m_cred[c] = m_cred[c] - 1;
                end else if (m_inc && !m_dec) begin
                    if (m_cred[c] == 4) m_err = 1; else m_cred[c] = m_cred[c] + 1;
                end
            end
            if (!m_was_locked) begin
                m_found = 0;
                for (int k = 0; k < 5; k++) begin
                    m_i = (m_ptr + k) % 5;
                    if (!m_found && req[m_i] && req_sop[m_i] && m_old[int'(req_vc[m_i])] > 0) begin
                        m_found  = 1;
                        m_locked = 1;
                        m_owner  = m_i;
                        m_vc     = int'(req_vc[m_i]);
                    end
                end
            end else if (out_fire && out_eop) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % 5;
            end
        end
    end

    always @(negedge noc_clk) begin
        if (chk_on && !noc_rst) begin
            chk("model grant", 32'(grant), m_locked ? (32'd1 << m_owner) : 32'd0);
            chk("model busy", 32'(busy), 32'(m_locked));
            chk("model send_en", 32'(send_en), 32'(m_locked && m_cred[m_vc] != 0));
            chk("model credit_cnt", 32'(credit_cnt), 32'(m_cred[1] * 8 + m_cred[0]));
            chk("model credit_err", 32'(credit_err), 32'(m_err));
            if (m_locked) chk("model grant_vc", 32'(grant_vc), 32'(m_vc));
        end
    end

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic idle_in();
        req = '0; req_sop = '0; req_vc = '0;
        out_fire = 1'b0; out_eop = 1'b0; credit_return = '0;
    endtask

    task automatic do_reset();
        noc_rst = 1'b1;
        idle_in();
        tick();
        tick();
        noc_rst = 1'b0;
        tick();
    endtask

    initial begin
        noc_rst = 1'b0;
        idle_in();
        #2;
        do_reset();
        chk_on = 1'b1;
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset send_en", 32'(send_en), 32'd0);
        chk("reset credit_cnt", 32'(credit_cnt), 32'd36);
        chk("reset credit_err", 32'(credit_err), 32'd0);

        // T1: single input on VC1, 4-flit packet drains VC1, then pointer at 3.
        req = 5'b00100; req_sop = 5'b00100; req_vc = 5'b00100;
        tick();
        chk("T1 grant", 32'(grant), 32'h04);
        chk("T1 grant_vc", 32'(grant_vc), 32'd1);
        chk("T1 send_en", 32'(send_en), 32'd1);
        req_sop = '0; out_fire = 1'b1;
        repeat (3) tick();
        out_eop = 1'b1; req = '0;
        tick();
        out_fire = 1'b0; out_eop = 1'b0;
        chk("T1 grant drop", 32'(grant), 32'd0);
        chk("T1 credit", 32'(credit_cnt), 32'd4);
        credit_return = 2'b10;
        repeat (4) tick();
        credit_return = '0;
        req = 5'b01001; req_sop = 5'b01001; req_vc = '0;
        tick();
        chk("T1 rr_ptr winner", 32'(grant), 32'h08);
        req = '0; req_sop = '0; out_fire = 1'b1; out_eop = 1'b1;
        tick();
        idle_in(); credit_return = 2'b01;
        tick();
        credit_return = '0;

        // T2: all inputs, single-flit packets, fairness with idle bubbles.
        do_reset();
        req = 5'b11111; req_sop = 5'b11111; req_vc = '0;
        tick();
        for (int k = 0; k < 12; k++) begin
            chk("T2 order", 32'(grant), (k % 2 == 0) ? (32'd1 << ((k / 2) % 5)) : 32'd0);
            out_fire = (grant != '0);
            out_eop = out_fire;
            credit_return = {1'b0, out_fire};
            tick();
        end
        idle_in();

        // T3/T4: credit exhaustion, return, simultaneous inc/dec, overflow.
        do_reset();
        req = 5'b00001; req_sop = 5'b00001; req_vc = '0;
        tick();
        chk("T3 grant", 32'(grant), 32'h01);
        req_sop = '0; out_fire = 1'b1;
        repeat (4) tick();
        out_fire = 1'b0;
        chk("T3 send_en at zero", 32'(send_en), 32'd0);
        chk("T3 credit zero", 32'(credit_cnt), 32'd32);
        credit_return = 2'b01;
        tick();
        credit_return = '0;
        chk("T3 send_en back", 32'(send_en), 32'd1);
        credit_return = 2'b01;
        tick();
        out_fire = 1'b1; credit_return = 2'b01;
        tick();
        out_fire = 1'b0; credit_return = '0;
        chk("T4 inc+dec", 32'(credit_cnt), 32'd34);
        chk("T4 err clear", 32'(credit_err), 32'd0);
        credit_return = 2'b10;
        tick();
        credit_return = '0;
        chk("T4 overflow cnt", 32'(credit_cnt), 32'd34);
        chk("T4 overflow err", 32'(credit_err), 32'd1);
        req = '0; out_fire = 1'b1; out_eop = 1'b1;
        tick();
        idle_in();
        tick();
        chk("T4 err sticky", 32'(credit_err), 32'd1);

        // T5: wormhole lock survives req drop while another input waits.
        do_reset();
        chk("T5 err reset", 32'(credit_err), 32'd0);
        req = 5'b00010; req_sop = 5'b00010; req_vc = '0;
        tick();
        chk("T5 grant", 32'(grant), 32'h02);
        req_sop = '0; out_fire = 1'b1;
        tick();
        out_fire = 1'b0;
        req = 5'b01000; req_sop = 5'b01000;
        repeat (3) tick();
        chk("T5 lock held", 32'(grant), 32'h02);
        out_fire = 1'b1; out_eop = 1'b1;
        tick();
        out_fire = 1'b0; out_eop = 1'b0;
        chk("T5 bubble", 32'(grant), 32'd0);
        tick();
        chk("T5 next grant", 32'(grant), 32'h08);
        req = '0; req_sop = '0; out_fire = 1'b1; out_eop = 1'b1;
        tick();
        idle_in();

        // T6: asynchronous reset mid-packet with credits VC1=3, VC0=1.
        do_reset();
        req = 5'b00001; req_sop = 5'b00001; req_vc = 5'b00001;
        tick();
        chk("T6 grant vc1", 32'(grant_vc), 32'd1);
        req = '0; req_sop = '0; out_fire = 1'b1; out_eop = 1'b1;
        tick();
        out_fire = 1'b0; out_eop = 1'b0;
        req = 5'b00100; req_sop = 5'b00100; req_vc = '0;
        tick();
        chk("T6 grant input2", 32'(grant), 32'h04);
        req_sop = '0; out_fire = 1'b1;
        repeat (3) tick();
        out_fire = 1'b0;
        chk("T6 credits 3/1", 32'(credit_cnt), 32'd25);
        #2;
        noc_rst = 1'b1;
        #1;
        chk("T6 async grant", 32'(grant), 32'd0);
        chk("T6 async busy", 32'(busy), 32'd0);
        chk("T6 async send_en", 32'(send_en), 32'd0);
        chk("T6 async credit", 32'(credit_cnt), 32'd36);
        idle_in();
        tick();
        tick();
        noc_rst = 1'b0;
        tick();
        chk("T6 post grant", 32'(grant), 32'd0);
        chk("T6 post credit", 32'(credit_cnt), 32'd36);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_switch_allocator.md
Name: noc_switch_allocator

Overview:
Per-output-port allocator for the 5-port NoC router: one instance per output block (east, west, south, north, local). Arbitrates the five input blocks' packet requests with round-robin fairness and wormhole packet locking. Tracks downstream per-VC credits and gates flit transfer so the downstream VC buffer never overflows.

Parameters:
NUM_INPUTS, 5, number of requesting input blocks
CHANNELS, Noc_VC_Channel, number of virtual channels on the output link
CREDIT_DEPTH, 4, downstream buffer depth per VC in flits
VC_W, max(1,$clog2(CHANNELS)), derived, width of a VC index
CNT_W, $clog2(CREDIT_DEPTH+1), derived, width of a credit counter

Ports:
noc_clk  in  1  router clock
noc_rst  in  1  asynchronous active-high reset
req  in  NUM_INPUTS  input i has a head or body flit pending for this output
req_sop  in  NUM_INPUTS  input i's pending flit is a head flit
req_vc  in  NUM_INPUTS*VC_W  target VC of input i, packed with input i at [i*VC_W +: VC_W]
out_fire  in  1  flit from the granted input transferred this cycle (valid & ready)
out_eop  in  1  the flit transferred by out_fire is a tail flit
credit_return  in  CHANNELS  downstream freed one slot of VC c this cycle
grant  out  NUM_INPUTS  registered one-hot grant, all-zero when idle
grant_vc  out  VC_W  VC locked by the current grant
send_en  out  1  grant held and locked VC has credit >0; qualifies ready to the granted input
busy  out  1  state is LOCKED
credit_cnt  out  CHANNELS*CNT_W  current credit per VC
credit_err  out  1  sticky protocol-violation flag

Behaviour:
- Interface decision: one clock, noc_clk. Reset is asynchronous and active-high, noc_rst.
- Reset values:
  - grant=0, grant_vc=0, send_en=0, busy=0, credit_err=0.
  - Every credit counter = CREDIT_DEPTH.
  - rr_ptr=0, state=IDLE.
  - Reset asserted mid-packet abandons the lock immediately; no partial state survives.
- FSM states: IDLE and LOCKED.
- IDLE:
  - eligible[i] = req[i] & req_sop[i] & (credit[req_vc[i]] != 0).
  - Winner = first eligible index scanning from rr_ptr upward, modulo NUM_INPUTS.
  - If any input is eligible: next edge sets grant=onehot(winner), grant_vc=req_vc[winner], state=LOCKED.
  - Latency from req to grant is exactly 1 cycle.
- LOCKED:
  - grant and grant_vc hold constant.
  - send_en = (credit[grant_vc] != 0), combinational from registered state.
  - Deasserting req without a tail does not release the lock (wormhole).
  - out_fire & out_eop: next edge sets grant=0, state=IDLE, rr_ptr=(winner+1) mod NUM_INPUTS. This gives one idle bubble cycle before the next grant.
  - Single-flit packets (head = tail) follow the same rule.
- Credits, per VC c, next = cnt - dec + inc:
  - dec = out_fire & busy & (grant_vc==c).
  - inc = credit_return[c].
  - dec and inc in the same cycle on the same VC leave the count unchanged.
  - Count saturates at CREDIT_DEPTH: an inc at full count is dropped and sets credit_err.
  - A dec at zero count is dropped and sets credit_err.
  - out_fire while IDLE is ignored and sets credit_err.
- credit_err clears only on reset.
- Assertions required in RTL:
  - grant is one-hot or zero.
  - out_fire implies send_en.

Decomposition:
- Noc_parameters package gains:
  - CREDIT_DEPTH default constant (Noc_VC_Credit_Depth).
  - typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} noc_alloc_state_e.
  - Credit counter width function.
- One sub-module: noc_rr_arbiter.
  - Purely combinational.
  - Inputs: request vector, pointer. Outputs: one-hot winner, any_grant.
  - Parameterised by NUM_INPUTS; reused later by the VC allocator.

Test Plan:
1. Reset then req=5'b00100, sop=1, vc=1 -> grant=5'b00100 one cycle later, grant_vc=1, send_en=1. Three fires then fire+eop -> credit[1] 4→0. Grant drops the next cycle; rr_ptr=3.
2. All five inputs request head flits continuously with single-flit packets -> grant order 0,1,2,3,4,0, with one idle cycle between grants.
3. Lock on VC0 with credit 4; fire 4 flits with no returns -> send_en=0 at count 0. credit_return[0] pulse -> send_en=1 the next cycle.
4. Simultaneous out_fire and credit_return[0] on VC0 at count 2 -> count stays 2. credit_return[1] at count 4 -> count stays 4 and credit_err=1.
5. Input 1 locked mid-packet; input 1 req drops while input 3 requests -> grant stays 5'b00010 until out_eop fire.
6. noc_rst asserted asynchronously mid-packet with credits 1/3 -> outputs clear immediately without a clock edge. Credits read 4/4 and grant=0 after release.
